mem_stage: RTL and testbench



---
 rtl/mips_defs.sv | 83 ++++++++
 rtl/dm_ram.sv | 45 ++++
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Shared MIPS encodings for the memory stage: opcode/funct
//                constants, instruction field positions, write-back source
//                select and memory access sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Instruction field bit ranges
    localparam int c_OP_HI = 31;
    localparam int c_OP_LO = 26;
    localparam int c_RT_HI = 20;
    localparam int c_RT_LO = 16;
    localparam int c_RD_HI = 15;
    localparam int c_RD_LO = 11;
    localparam int c_FN_HI = 5;
    localparam int c_FN_LO = 0;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE  = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM = 6'b000001;
    localparam logic [5:0] c_OP_JAL    = 6'b000011;
    localparam logic [5:0] c_OP_ADDI   = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU  = 6'b001001;
    localparam logic [5:0] c_OP_SLTI   = 6'b001010;
    localparam logic [5:0] c_OP_SLTIU  = 6'b001011;
    localparam logic [5:0] c_OP_ANDI   = 6'b001100;
    localparam logic [5:0] c_OP_ORI    = 6'b001101;
    localparam logic [5:0] c_OP_XORI   = 6'b001110;
    localparam logic [5:0] c_OP_LUI    = 6'b001111;
    localparam logic [5:0] c_OP_LB     = 6'b100000;
    localparam logic [5:0] c_OP_LH     = 6'b100001;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_LBU    = 6'b100100;
    localparam logic [5:0] c_OP_LHU    = 6'b100101;
    localparam logic [5:0] c_OP_SB     = 6'b101000;
    localparam logic [5:0] c_OP_SH     = 6'b101001;
    localparam logic [5:0] c_OP_SW     = 6'b101011;

    // REGIMM rt selector for bgezal
    localparam logic [4:0] c_RT_BGEZAL = 5'b10001;

    // R-type funct codes with special write-back handling
    localparam logic [5:0] c_FN_JALR = 6'b001001;
    localparam logic [5:0] c_FN_MOVZ = 6'b001010;
    localparam logic [5:0] c_FN_MOVN = 6'b001011;

    // Write-back source select
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC8 = 2'b10
    } wbsel_e;

    // Memory access size
    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } accsize_e;

    // R-type functs that produce a GRF result from the ALU or HI/LO
    function automatic logic isRAluFunct(input logic [5:0] fn);
        logic r;
        case (fn)
            6'b000000, 6'b000010, 6'b000011,             // sll srl sra
            6'b000100, 6'b000110, 6'b000111,             // sllv srlv srav
            6'b010000, 6'b010010,                        // mfhi mflo
            6'b100000, 6'b100001, 6'b100010, 6'b100011,  // add addu sub subu
            6'b100100, 6'b100101, 6'b100110, 6'b100111,  // and or xor nor
            6'b101010, 6'b101011:                        // slt sltu
                r = 1'b1;
            default:
                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dm_ram
//  Description : DM_WORDS x 32 data memory with per-byte write enables,
//                asynchronous read and a synchronous clear of every word.
//  Ports       : clk    - clock
//                reset  - synchronous active-low clear of the whole array
//                addr   - word address
//                byteEn - per-lane write enables (bit 3 = bits 31:24)
//                wData  - write data, already lane-positioned
//                rData  - asynchronous read data of word addr
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_ram #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DM_AW-1:0] addr,
    input  logic [3:0]       byteEn,
    input  logic [31:0]      wData,
    output logic [31:0]      rData
);

    logic [31:0] r_mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < DM_WORDS; w++) begin
                r_mem[w] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    r_mem[addr][8*b +: 8] <= wData[8*b +: 8];
                end
            end
        end
    end

    assign rData = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS pipeline memory stage. Holds the EX/MEM register,
//                the byte-addressable data memory (store merging, load
//                extraction/extension), the M-stage forwarding value and
//                the write-back controls for MEM/WB.
//  Ports       : clk, reset (sync, active-low)
//                InstrE/PCplus8E/ALUOutE/RTE/movWriteE/WriteRegE - EX results
//                InstrM/PCplus8M/ALUOutM/WriteRegM - latched values
//                RegWriteM - GRF write enable, WBSelM - write-back source
//                MF_selM   - forwarding value, ReadDataM - load result
//                AddrErrM  - misaligned / out-of-range access
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_defs::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrE,
    input  logic [31:0] PCplus8E,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] RTE,
    input  logic        movWriteE,
    input  logic [4:0]  WriteRegE,
    output logic [31:0] InstrM,
    output logic [31:0] PCplus8M,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic [31:0] MF_selM,
    output logic [31:0] ReadDataM,
    output logic [1:0]  WBSelM,
    output logic        AddrErrM
);

    localparam logic [29:0] c_DM_LIMIT = 30'(DM_WORDS);

    // ---------------- EX/MEM register ----------------
    logic [31:0] r_instrM;
    logic [31:0] r_pcPlus8M;
    logic [31:0] r_aluOutM;
    logic [31:0] r_rtM;
    logic        r_movWriteM;
    logic [4:0]  r_writeRegM;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instrM    <= '0;
            r_pcPlus8M  <= '0;
            r_aluOutM   <= '0;
            r_rtM       <= '0;
            r_movWriteM <= 1'b0;
            r_writeRegM <= '0;
        end else begin
            r_instrM    <= InstrE;
            r_pcPlus8M  <= PCplus8E;
            r_aluOutM   <= ALUOutE;
            r_rtM       <= RTE;
            r_movWriteM <= movWriteE;
            r_writeRegM <= WriteRegE;
        end
    end

    // ---------------- Decode ----------------
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic       w_decWrite;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isLink;
    logic       w_signed;
    accsize_e   w_size;

    assign w_op = r_instrM[c_OP_HI:c_OP_LO];
    assign w_fn = r_instrM[c_FN_HI:c_FN_LO];
    assign w_rt = r_instrM[c_RT_HI:c_RT_LO];

    always_comb begin
        w_decWrite = 1'b0;
        w_isLoad   = 1'b0;
        w_isStore  = 1'b0;
        w_isLink   = 1'b0;
        w_signed   = 1'b0;
        w_size     = SZ_NONE;
        case (w_op)
            c_OP_RTYPE: begin
                if (w_fn == c_FN_JALR) begin
                    w_decWrite = 1'b1;
                    w_isLink   = 1'b1;
                end else if (w_fn == c_FN_MOVZ || w_fn == c_FN_MOVN) begin
                    // Condition was resolved in EX and travels with the instr
                    w_decWrite = r_movWriteM;
                end else begin
                    w_decWrite = isRAluFunct(w_fn);
                end
            end
            c_OP_REGIMM: begin
                if (w_rt == c_RT_BGEZAL) begin
                    w_decWrite = 1'b1;
                    w_isLink   = 1'b1;
                end
            end
            c_OP_JAL: begin
                w_decWrite = 1'b1;
                w_isLink   = 1'b1;
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
            c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
                w_decWrite = 1'b1;
            end
            c_OP_LB:  begin w_decWrite = 1'b1; w_isLoad = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
            c_OP_LBU: begin w_decWrite = 1'b1; w_isLoad = 1'b1; w_size = SZ_BYTE; end
            c_OP_LH:  begin w_decWrite = 1'b1; w_isLoad = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
            c_OP_LHU: begin w_decWrite = 1'b1; w_isLoad = 1'b1; w_size = SZ_HALF; end
            c_OP_LW:  begin w_decWrite = 1'b1; w_isLoad = 1'b1; w_size = SZ_WORD; end
            c_OP_SB:  begin w_isStore = 1'b1; w_size = SZ_BYTE; end
            c_OP_SH:  begin w_isStore = 1'b1; w_size = SZ_HALF; end
            c_OP_SW:  begin w_isStore = 1'b1; w_size = SZ_WORD; end
            default: ;
        endcase
    end

    // ---------------- Address check ----------------
    logic [31:0] w_addr;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_addrErr;

    assign w_addr       = r_aluOutM;
    assign w_misaligned = ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00)) ||
                          ((w_size == SZ_HALF) && w_addr[0]);
    assign w_outOfRange = (w_addr[31:2] >= c_DM_LIMIT);
    assign w_addrErr    = (w_isLoad || w_isStore) && (w_misaligned || w_outOfRange);

    // ---------------- Store lane placement ----------------
    logic [3:0]  w_byteEn;
    logic [31:0] w_wData;

    always_comb begin
        w_byteEn = 4'b0000;
        w_wData  = r_rtM;
        case (w_size)
            SZ_BYTE: begin
                w_wData  = {4{r_rtM[7:0]}};
                w_byteEn = 4'b0001 << w_addr[1:0];
            end
            SZ_HALF: begin
                w_wData  = {2{r_rtM[15:0]}};
                w_byteEn = w_addr[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                w_byteEn = 4'b1111;
            end
            default: ;
        endcase
        if (!w_isStore || w_addrErr) begin
            w_byteEn = 4'b0000;
        end
    end

    // ---------------- Data memory ----------------
    logic [31:0] w_ramRData;

    dm_ram #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dmRam (
        .clk    (clk),
        .reset  (reset),
        .addr   (w_addr[DM_AW+1:2]),
        .byteEn (w_byteEn),
        .wData  (w_wData),
        .rData  (w_ramRData)
    );

    // ---------------- Load lane extraction ----------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_ramRData[7:0];
            2'd1:    w_byte = w_ramRData[15:8];
            2'd2:    w_byte = w_ramRData[23:16];
            default: w_byte = w_ramRData[31:24];
        endcase
        w_half     = w_addr[1] ? w_ramRData[31:16] : w_ramRData[15:0];
        w_loadData = '0;
        case (w_size)
            SZ_BYTE: w_loadData = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_loadData = {{16{w_signed & w_half[15]}}, w_half};
            SZ_WORD: w_loadData = w_ramRData;
            default: ;
        endcase
    end

    // ---------------- Outputs ----------------
    wbsel_e w_wbSel;

    assign w_wbSel   = w_isLoad ? WB_MEM : (w_isLink ? WB_PC8 : WB_ALU);

    assign InstrM    = r_instrM;
    assign PCplus8M  = r_pcPlus8M;
    assign ALUOutM   = r_aluOutM;
    assign RegWriteM = w_decWrite && (r_writeRegM != 5'd0);
    assign WriteRegM = RegWriteM ? r_writeRegM : 5'd0;
    // Load data is never forwarded from M; load-use is stalled upstream
    assign MF_selM   = w_isLink ? r_pcPlus8M : r_aluOutM;
    assign ReadDataM = (w_isLoad && !w_addrErr) ? w_loadData : '0;
    assign WBSelM    = w_wbSel;
    assign AddrErrM  = w_addrErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. A word-array model of
//                memory and a copy of the EX/MEM contents predict every
//                output each cycle; directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrE, PCplus8E, ALUOutE, RTE;
    logic        movWriteE;
    logic [4:0]  WriteRegE;
    logic [31:0] InstrM, PCplus8M, ALUOutM, MF_selM, ReadDataM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, AddrErrM;
    logic [1:0]  WBSelM;

    always #5 clk = ~clk;

    mem_stage #(.DM_WORDS(1024), .DM_AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .InstrE    (InstrE),
        .PCplus8E  (PCplus8E),
        .ALUOutE   (ALUOutE),
        .RTE       (RTE),
        .movWriteE (movWriteE),
        .WriteRegE (WriteRegE),
        .InstrM    (InstrM),
        .PCplus8M  (PCplus8M),
        .ALUOutM   (ALUOutM),
        .WriteRegM (WriteRegM),
        .RegWriteM (RegWriteM),
        .MF_selM   (MF_selM),
        .ReadDataM (ReadDataM),
        .WBSelM    (WBSelM),
        .AddrErrM  (AddrErrM)
    );

    int errors = 0;
    int checks = 0;
    bit cmpEn  = 1'b0;

    // ---------------- Reference model ----------------
    logic [31:0] mm [int];          // word index -> word; absent means 0
    logic [31:0] mInstr, mPc8, mAlu, mRt;
    logic        mMov;
    logic [4:0]  mWr;

    function automatic logic [5:0] opOf(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic int accSize(input logic [31:0] ins);
        case (opOf(ins))
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit isLoad(input logic [31:0] ins);
        return opOf(ins) inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic bit isStore(input logic [31:0] ins);
        return opOf(ins) inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic bit isLink(input logic [31:0] ins);
        return (opOf(ins) == 6'h03) ||
               (opOf(ins) == 6'h00 && ins[5:0] == 6'h09) ||
               (opOf(ins) == 6'h01 && ins[20:16] == 5'h11);
    endfunction

    function automatic bit writesGrf(input logic [31:0] ins, input logic mov);
        if (isLoad(ins) || isLink(ins)) return 1'b1;
        if (opOf(ins) inside {[6'h08:6'h0F]}) return 1'b1;
        if (opOf(ins) == 6'h00) begin
            if (ins[5:0] inside {6'h0A, 6'h0B}) return mov;
            return ins[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                    6'h10, 6'h12, [6'h20:6'h27], 6'h2A, 6'h2B};
        end
        return 1'b0;
    endfunction

    function automatic bit badAddr(input logic [31:0] ins, input logic [31:0] a);
        int sz;
        sz = accSize(ins);
        if (sz == 0) return 1'b0;
        return ((a % 32'(sz)) != 0) || ((a >> 2) >= 32'd1024);
    endfunction

    function automatic logic [31:0] laneMask(input int sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] ins, input logic [31:0] a);
        logic [31:0] w, v, mask;
        int sz, sh;
        if (!isLoad(ins) || badAddr(ins, a)) return 32'd0;
        sz   = accSize(ins);
        sh   = 8 * int'(a % 32'd4);
        w    = mm.exists(int'(a >> 2)) ? mm[int'(a >> 2)] : 32'd0;
        mask = laneMask(sz);
        v    = (w >> sh) & mask;
        if ((opOf(ins) == 6'h20 || opOf(ins) == 6'h21) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Advance the model across one rising edge using the current inputs
    function automatic void modelTick();
        logic [31:0] old, mask;
        int sz, sh;
        if (!reset) begin
            mm.delete();
            mInstr = '0; mPc8 = '0; mAlu = '0; mRt = '0; mMov = 1'b0; mWr = '0;
        end else begin
            if (isStore(mInstr) && !badAddr(mInstr, mAlu)) begin
                sz   = accSize(mInstr);
                sh   = 8 * int'(mAlu % 32'd4);
                mask = laneMask(sz);
                old  = mm.exists(int'(mAlu >> 2)) ? mm[int'(mAlu >> 2)] : 32'd0;
                mm[int'(mAlu >> 2)] = (old & ~(mask << sh)) | ((mRt & mask) << sh);
            end
            mInstr = InstrE; mPc8 = PCplus8E; mAlu = ALUOutE;
            mRt = RTE; mMov = movWriteE; mWr = WriteRegE;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmpEn) begin
            logic expRw;
            expRw = writesGrf(mInstr, mMov) && (mWr != 5'd0);
            chk("cmp_InstrM",    InstrM,    mInstr);
            chk("cmp_PCplus8M",  PCplus8M,  mPc8);
            chk("cmp_ALUOutM",   ALUOutM,   mAlu);
            chk("cmp_RegWriteM", 32'(RegWriteM), 32'(expRw));
            chk("cmp_WriteRegM", 32'(WriteRegM), expRw ? 32'(mWr) : 32'd0);
            chk("cmp_MF_selM",   MF_selM,   isLink(mInstr) ? mPc8 : mAlu);
            chk("cmp_ReadDataM", ReadDataM, expRead(mInstr, mAlu));
            chk("cmp_WBSelM",    32'(WBSelM),
                isLoad(mInstr) ? 32'd1 : (isLink(mInstr) ? 32'd2 : 32'd0));
            chk("cmp_AddrErrM",  32'(AddrErrM), 32'(badAddr(mInstr, mAlu)));
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic step(input logic [31:0] ins, input logic [31:0] pc8,
                        input logic [31:0] alu, input logic [31:0] rt,
                        input logic mov, input logic [4:0] wr, input logic rst);
        InstrE = ins; PCplus8E = pc8; ALUOutE = alu; RTE = rt;
        movWriteE = mov; WriteRegE = wr; reset = rst;
        @(posedge clk);
        modelTick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] iIns(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd4, 5'd8, imm};
    endfunction

    logic [5:0] rFns [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B};
    logic [5:0] ldOps [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] stOps [3]  = '{6'h28, 6'h29, 6'h2B};

    initial begin
        logic [31:0] base, ins, alu;
        logic [4:0]  wr;
        int          k;

        // Reset with random inputs for two cycles
        repeat (2) step($urandom, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), 1'b0);
        cmpEn = 1'b1;
        chk("rst_InstrM",    InstrM,    32'd0);
        chk("rst_ALUOutM",   ALUOutM,   32'd0);
        chk("rst_MF_selM",   MF_selM,   32'd0);
        chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
        chk("rst_WBSelM",    32'(WBSelM), 32'd0);

        step(iIns(6'h23, 16'h0), 32'd8, 32'h0, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lw0_data", ReadDataM, 32'd0);

        // sw then lw
        step(iIns(6'h2B, 16'h10), 32'd8, 32'h10, 32'h1234_5678, 1'b0, 5'd9, 1'b1);
        chk("sw_rw", 32'(RegWriteM), 32'd0);
        step(iIns(6'h23, 16'h10), 32'd8, 32'h10, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lw10_data", ReadDataM, 32'h1234_5678);
        chk("lw10_wbsel", 32'(WBSelM), 32'd1);
        chk("lw10_rw", 32'(RegWriteM), 32'd1);

        // Byte / half merge
        step(iIns(6'h2B, 16'h20), 32'd8, 32'h20, 32'h1234_5678, 1'b0, 5'd9, 1'b1);
        step(iIns(6'h28, 16'h21), 32'd8, 32'h21, 32'hFFFF_FFAB, 1'b0, 5'd9, 1'b1);
        step(iIns(6'h23, 16'h20), 32'd8, 32'h20, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("sb_merge", ReadDataM, 32'h1234_AB78);
        step(iIns(6'h20, 16'h21), 32'd8, 32'h21, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lb21", ReadDataM, 32'hFFFF_FFAB);
        step(iIns(6'h24, 16'h21), 32'd8, 32'h21, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lbu21", ReadDataM, 32'h0000_00AB);
        step(iIns(6'h29, 16'h22), 32'd8, 32'h22, 32'h0000_8001, 1'b0, 5'd9, 1'b1);
        step(iIns(6'h23, 16'h20), 32'd8, 32'h20, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("sh_merge", ReadDataM, 32'h8001_AB78);
        step(iIns(6'h21, 16'h22), 32'd8, 32'h22, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lh22", ReadDataM, 32'hFFFF_8001);

        // Misaligned / out-of-range
        step(iIns(6'h2B, 16'h13), 32'd8, 32'h13, 32'hDEAD_BEEF, 1'b0, 5'd9, 1'b1);
        chk("sw13_err", 32'(AddrErrM), 32'd1);
        step(iIns(6'h23, 16'h10), 32'd8, 32'h10, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("sw13_nowrite", ReadDataM, 32'h1234_5678);
        step(iIns(6'h23, 16'h1000), 32'd8, 32'h1000, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("lw1000_data", ReadDataM, 32'd0);
        chk("lw1000_err", 32'(AddrErrM), 32'd1);

        // Link and conditional move
        step({6'h03, 26'h0000C00}, 32'h0000_3008, 32'h5555_0000, 32'd0, 1'b0, 5'd31, 1'b1);
        chk("jal_mf", MF_selM, 32'h0000_3008);
        chk("jal_wr", 32'(WriteRegM), 32'd31);
        chk("jal_wbsel", 32'(WBSelM), 32'd2);
        step({6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h0A}, 32'd8, 32'h77, 32'd0, 1'b0, 5'd5, 1'b1);
        chk("movz_rw", 32'(RegWriteM), 32'd0);
        chk("movz_wr", 32'(WriteRegM), 32'd0);

        // Reset while a store is in M
        step(iIns(6'h2B, 16'h4), 32'd8, 32'h4, 32'hFFFF_FFFF, 1'b0, 5'd9, 1'b1);
        step(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        step(iIns(6'h23, 16'h4), 32'd8, 32'h4, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("rststore_4", ReadDataM, 32'd0);
        step(iIns(6'h23, 16'h10), 32'd8, 32'h10, 32'd0, 1'b0, 5'd8, 1'b1);
        chk("rststore_10", ReadDataM, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            base = $urandom;
            k    = $urandom_range(0, 13);
            case (k)
                0:  ins = 32'd0;
                1:  ins = {6'h00, base[25:6], rFns[$urandom_range(0, 17)]};
                2:  ins = {3'b001, 3'($urandom), base[25:0]};
                3:  ins = {ldOps[$urandom_range(0, 4)], base[25:0]};
                4:  ins = {stOps[$urandom_range(0, 2)], base[25:0]};
                5:  ins = {6'h03, base[25:0]};
                6:  ins = {6'h00, base[25:6], 6'h09};
                7:  ins = {6'h01, base[25:21], 5'h11, base[15:0]};
                8:  ins = {6'h00, base[25:6], 6'h0A};
                9:  ins = {6'h00, base[25:6], 6'h0B};
                10: ins = {6'h00, base[25:6], 6'h18};
                11: ins = {6'h00, base[25:6], 6'h08};
                12: ins = {6'h04, base[25:0]};
                default: ins = {6'h01, base[25:21], 5'h00, base[15:0]};
            endcase
            if (k == 3 || k == 4) begin
                alu = 32'($urandom_range(0, 63)) * 32'd4;
                if ($urandom_range(0, 3) == 0) alu = alu + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 9) == 0) alu = $urandom;
            end else begin
                alu = $urandom;
            end
            wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(ins, $urandom, alu, $urandom, 1'($urandom), wr,
                 ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);
        end

        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
